// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared core-state, lsu-state and register-mux definitions
package gpu_pkg;

    // Scheduler core_state encodings
    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_WAIT    = 3'b100;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;
    localparam logic [2:0] CORE_DONE    = 3'b111;

    // Register-file input mux selects (shared with register file and scheduler)
    localparam logic [1:0] REG_ARITHMETIC = 2'b00;
    localparam logic [1:0] REG_MEMORY     = 2'b01;
    localparam logic [1:0] REG_CONSTANT   = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'b00,
        LSU_REQUESTING = 2'b01,
        LSU_WAITING    = 2'b10,
        LSU_DONE       = 2'b11
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - data-memory valid/ready port between LSU and memory controller
interface load_store_unit_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
);
    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;
    logic                 mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic                 mem_write_ready;

    modport master (
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );

    modport slave (
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );
endinterface

// File: rtl/lsu_watchdog.sv
// rtl/lsu_watchdog.sv - handshake watchdog counter, built only with LSU_TIMEOUT_EN
`ifdef LSU_TIMEOUT_EN
module lsu_watchdog #(
    parameter int LIMIT = 64,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         enable_i,
    input  logic         load_i,
    input  logic [W-1:0] load_value_i,
    output logic         expired_o
);
    logic [W-1:0] count_q, count_d;

    // Expiry is flagged during the LIMIT-th counted cycle so the owner leaves on that edge
    assign expired_o = (count_q >= W'(LIMIT - 1));

    // Clear dominates load; counting saturates once expired
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_value_i;
        end else if (enable_i && !expired_o) begin
            count_d = count_q + W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end
endmodule
`endif

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - per-thread LDR/STR unit; optional watchdog via LSU_TIMEOUT_EN
module load_store_unit
    import gpu_pkg::*;
#(
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 thread_active,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    load_store_unit_if.master    mem,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out,
    output logic                 lsu_error
);
    lsu_state_t           state_q, state_d;
    logic                 is_read_q, is_read_d;
    logic                 rvalid_q, rvalid_d;
    logic [ADDR_BITS-1:0] raddr_q, raddr_d;
    logic                 wvalid_q, wvalid_d;
    logic [ADDR_BITS-1:0] waddr_q, waddr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic [DATA_BITS-1:0] out_q, out_d;
    logic                 error_q, error_d;
    logic                 advance;
    logic                 wd_expired;

    assign advance = enable && thread_active;

`ifdef LSU_TIMEOUT_EN
    lsu_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk          (clk),
        .rst_n        (reset),
        .clear_i      (state_q != LSU_WAITING),
        .enable_i     (advance && (state_q == LSU_WAITING)),
        .load_i       (1'b0),
        .load_value_i ('0),
        .expired_o    (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    // Next-state and registered-output values; everything holds unless the thread may advance
    always_comb begin
        state_d   = state_q;
        is_read_d = is_read_q;
        rvalid_d  = rvalid_q;
        raddr_d   = raddr_q;
        wvalid_d  = wvalid_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        out_d     = out_q;
        error_d   = error_q;
        if (advance) begin
            case (state_q)
                LSU_IDLE: begin
                    if (core_state == CORE_REQUEST &&
                        (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                        state_d   = LSU_REQUESTING;
                        is_read_d = decoded_mem_read_enable;   // read wins over write
                        error_d   = 1'b0;
                    end
                end
                LSU_REQUESTING: begin
                    if (is_read_q) begin
                        rvalid_d = 1'b1;
                        raddr_d  = rs[ADDR_BITS-1:0];
                    end else begin
                        wvalid_d = 1'b1;
                        waddr_d  = rs[ADDR_BITS-1:0];
                        wdata_d  = rt;
                    end
                    state_d = LSU_WAITING;
                end
                LSU_WAITING: begin
                    if (is_read_q && mem.mem_read_ready) begin
                        rvalid_d = 1'b0;
                        out_d    = mem.mem_read_data;
                        state_d  = LSU_DONE;
                    end else if (!is_read_q && mem.mem_write_ready) begin
                        wvalid_d = 1'b0;
                        state_d  = LSU_DONE;
                    end else if (wd_expired) begin
                        rvalid_d = 1'b0;
                        wvalid_d = 1'b0;
                        error_d  = 1'b1;
                        if (is_read_q) out_d = '0;
                        state_d  = LSU_DONE;
                    end
                end
                LSU_DONE: begin
                    if (core_state == CORE_UPDATE) state_d = LSU_IDLE;
                end
                default: state_d = LSU_IDLE;
            endcase
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= LSU_IDLE;
            is_read_q <= 1'b0;
            rvalid_q  <= 1'b0;
            raddr_q   <= '0;
            wvalid_q  <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            out_q     <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_read_q <= is_read_d;
            rvalid_q  <= rvalid_d;
            raddr_q   <= raddr_d;
            wvalid_q  <= wvalid_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            out_q     <= out_d;
            error_q   <= error_d;
        end
    end

    assign mem.mem_read_valid    = rvalid_q;
    assign mem.mem_read_address  = raddr_q;
    assign mem.mem_write_valid   = wvalid_q;
    assign mem.mem_write_address = waddr_q;
    assign mem.mem_write_data    = wdata_q;
    assign lsu_state             = state_q;
    assign lsu_out               = out_q;
`ifdef LSU_TIMEOUT_EN
    assign lsu_error             = error_q;
`else
    assign lsu_error             = 1'b0;
`endif

    // Shared package constants and the watchdog limit are not all needed by this block
    logic unused_consts;
    assign unused_consts = ^{CORE_WAIT, CORE_DONE, REG_ARITHMETIC, REG_MEMORY, REG_CONSTANT,
                             (TIMEOUT_CYCLES != 0), error_q};
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;
    import gpu_pkg::*;

    localparam int AB = 8;
    localparam int DB = 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          thread_active = 1'b0;
    logic [2:0]    core_state = 3'b000;
    logic          rd_en = 1'b0;
    logic          wr_en = 1'b0;
    logic [DB-1:0] rs = '0;
    logic [DB-1:0] rt = '0;
    logic [1:0]    lsu_state;
    logic [DB-1:0] lsu_out;
    logic          lsu_error;

    load_store_unit_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) mem_if ();

    load_store_unit #(.ADDR_BITS(AB), .DATA_BITS(DB), .TIMEOUT_CYCLES(TO)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .enable                   (enable),
        .thread_active            (thread_active),
        .core_state               (core_state),
        .decoded_mem_read_enable  (rd_en),
        .decoded_mem_write_enable (wr_en),
        .rs                       (rs),
        .rt                       (rt),
        .mem                      (mem_if.master),
        .lsu_state                (lsu_state),
        .lsu_out                  (lsu_out),
        .lsu_error                (lsu_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [DB-1:0] model_out = '0;   // last loaded value the unit should present

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, lsu_state, 0);
        check({tag, "_rvalid"}, mem_if.mem_read_valid, 0);
        check({tag, "_raddr"}, mem_if.mem_read_address, 0);
        check({tag, "_wvalid"}, mem_if.mem_write_valid, 0);
        check({tag, "_waddr"}, mem_if.mem_write_address, 0);
        check({tag, "_wdata"}, mem_if.mem_write_data, 0);
        check({tag, "_out"}, lsu_out, 0);
        check({tag, "_err"}, lsu_error, 0);
    endtask

    // One instruction end to end. Expected behaviour: REQUESTING one edge after REQUEST,
    // valid on the next edge, held with stable address/data until the first enabled cycle
    // in which the matching ready is high, then DONE until UPDATE is seen.
    task automatic run_txn(input bit rd, input bit wr, input int delay, input bit stalls,
                           input logic [DB-1:0] a, input logic [DB-1:0] d,
                           input logic [DB-1:0] m, output int vcycles);
        bit is_rd;
        bit go;
        bit en;
        bit rdy;
        bit completing;
        bit done;
        int eff;
        int cyc;
        int hold;
        logic [2:0] cs_pick [3];
        cs_pick[0] = CORE_WAIT;
        cs_pick[1] = CORE_DONE;
        cs_pick[2] = CORE_REQUEST;
        is_rd   = rd;
        go      = rd | wr;
        vcycles = 0;

        core_state = CORE_REQUEST;
        rd_en = rd;
        wr_en = wr;
        rs = a;
        rt = d;
        mem_if.mem_read_ready  = 1'($urandom);
        mem_if.mem_write_ready = 1'($urandom);
        mem_if.mem_read_data   = DB'($urandom);
        tick();
        check("req_state", lsu_state, go ? 32'd1 : 32'd0);
        check("req_rvalid", mem_if.mem_read_valid, 0);
        check("req_wvalid", mem_if.mem_write_valid, 0);
        if (!go) begin
            core_state = 3'b000;
            return;
        end
`ifdef LSU_TIMEOUT_EN
        check("req_err_cleared", lsu_error, 0);
`endif
        // Operands stay valid through the REQUESTING cycle; decode and core_state do not
        core_state = CORE_WAIT;
        rd_en = 1'b0;
        wr_en = 1'b0;
        mem_if.mem_read_ready  = 1'($urandom);
        mem_if.mem_write_ready = 1'($urandom);
        tick();
        check("issue_state", lsu_state, 2);
        check("issue_rvalid", mem_if.mem_read_valid, 32'(is_rd));
        check("issue_wvalid", mem_if.mem_write_valid, 32'(!is_rd));
        if (is_rd) check("issue_raddr", mem_if.mem_read_address, 32'(a));
        else begin
            check("issue_waddr", mem_if.mem_write_address, 32'(a));
            check("issue_wdata", mem_if.mem_write_data, 32'(d));
        end
        vcycles = 1;
        rs = DB'($urandom);
        rt = DB'($urandom);

        eff = 0;
        done = 1'b0;
        cyc = 0;
        while (!done && cyc < 200) begin
            en  = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
            rdy = (eff >= delay);
            enable = en;
            core_state = cs_pick[$urandom_range(0, 2)];
            if (is_rd) begin
                mem_if.mem_read_ready  = rdy;
                mem_if.mem_write_ready = 1'($urandom);
            end else begin
                mem_if.mem_write_ready = rdy;
                mem_if.mem_read_ready  = 1'($urandom);
            end
            mem_if.mem_read_data = rdy ? m : DB'($urandom);
            completing = en && rdy;
            if (en) eff++;
            tick();
            cyc++;
            if (completing) begin
                done = 1'b1;
                if (is_rd) model_out = m;
                check("done_state", lsu_state, 3);
                check("done_rvalid", mem_if.mem_read_valid, 0);
                check("done_wvalid", mem_if.mem_write_valid, 0);
                check("done_out", lsu_out, 32'(model_out));
                check("done_err", lsu_error, 0);
            end else begin
                vcycles++;
                check("wait_state", lsu_state, 2);
                if (is_rd) begin
                    check("wait_rvalid", mem_if.mem_read_valid, 1);
                    check("wait_raddr", mem_if.mem_read_address, 32'(a));
                end else begin
                    check("wait_wvalid", mem_if.mem_write_valid, 1);
                    check("wait_waddr", mem_if.mem_write_address, 32'(a));
                    check("wait_wdata", mem_if.mem_write_data, 32'(d));
                end
                check("wait_out", lsu_out, 32'(model_out));
            end
        end
        enable = 1'b1;
        mem_if.mem_read_ready  = 1'b0;
        mem_if.mem_write_ready = 1'b0;
        if (!done) check("wait_bound_expired", 0, 1);

        hold = $urandom_range(0, 3);
        core_state = CORE_WAIT;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("done_hold", lsu_state, 3);
        end
        core_state = CORE_UPDATE;
        tick();
        check("update_idle", lsu_state, 0);
        check("update_out", lsu_out, 32'(model_out));
        core_state = 3'b000;
    endtask

    initial begin
        int vc;
        int op;
        int dly;
        int max_dly;
        mem_if.mem_read_ready  = 1'b0;
        mem_if.mem_write_ready = 1'b0;
        mem_if.mem_read_data   = '0;
`ifdef LSU_TIMEOUT_EN
        max_dly = TO - 1;
`else
        max_dly = 7;
`endif

        // Reset state with stimulus toggling underneath
        enable = 1'b1;
        thread_active = 1'b1;
        core_state = CORE_REQUEST;
        rd_en = 1'b1;
        rs = 8'h77;
        tick();
        tick();
        check_all_zero("reset");
        core_state = 3'b000;
        rd_en = 1'b0;
        reset = 1'b1;
        tick();
        check("post_reset_idle", lsu_state, 0);

        // Directed load: rs=12, data=A5, ready already high
        run_txn(1'b1, 1'b0, 0, 1'b0, 8'h12, 8'h00, 8'hA5, vc);
        check("load_valid_cycles", vc, 1);
        check("load_out_A5", lsu_out, 32'h0A5);

        // Directed store: rs=40, rt=3C, ready delayed 5 cycles
        run_txn(1'b0, 1'b1, 5, 1'b0, 8'h40, 8'h3C, 8'h00, vc);
        check("store_valid_cycles", vc, 6);
        check("store_keeps_out", lsu_out, 32'h0A5);

        // Both enables: read wins
        run_txn(1'b1, 1'b1, 2, 1'b0, 8'h5A, 8'hC3, 8'h6E, vc);
        check("both_valid_cycles", vc, 3);

        // Inactive thread never leaves IDLE
        thread_active = 1'b0;
        core_state = CORE_REQUEST;
        rd_en = 1'b1;
        rs = 8'h21;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("inactive_state", lsu_state, 0);
            check("inactive_rvalid", mem_if.mem_read_valid, 0);
        end
        core_state = 3'b000;
        rd_en = 1'b0;
        thread_active = 1'b1;
        tick();

        // Randomized instructions with stalls and core_state churn
        for (int t = 0; t < 30; t++) begin
            op  = $urandom_range(0, 3);
            dly = $urandom_range(0, max_dly);
            run_txn(op == 0 || op == 2, op == 1 || op == 2, dly, 1'b1,
                    DB'($urandom), DB'($urandom), DB'($urandom), vc);
            if (op != 3) check("rand_valid_min", 32'(vc >= dly + 1), 1);
        end

`ifdef LSU_TIMEOUT_EN
        // Watchdog: load with ready never high times out after TO waiting cycles
        core_state = CORE_REQUEST;
        rd_en = 1'b1;
        rs = 8'h99;
        mem_if.mem_read_data = 8'hFF;
        tick();
        check("to_req", lsu_state, 1);
        core_state = CORE_WAIT;
        rd_en = 1'b0;
        tick();
        check("to_wait0", lsu_state, 2);
        for (int i = 1; i < TO; i++) begin
            tick();
            check("to_wait", lsu_state, 2);
        end
        tick();
        model_out = '0;
        check("to_done", lsu_state, 3);
        check("to_err", lsu_error, 1);
        check("to_out", lsu_out, 0);
        check("to_rvalid", mem_if.mem_read_valid, 0);
        core_state = CORE_UPDATE;
        tick();
        check("to_idle", lsu_state, 0);
        check("to_err_held", lsu_error, 1);
        core_state = 3'b000;
        run_txn(1'b0, 1'b1, 1, 1'b0, 8'h10, 8'h20, 8'h00, vc);
`endif

        // Asynchronous reset while WAITING
        core_state = CORE_REQUEST;
        rd_en = 1'b1;
        rs = 8'hE1;
        tick();
        core_state = CORE_WAIT;
        rd_en = 1'b0;
        tick();
        check("pre_reset_wait", lsu_state, 2);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_out = '0;
        tick();
        reset = 1'b1;
        tick();
        check("after_reset_idle", lsu_state, 0);
        check("after_reset_rvalid", mem_if.mem_read_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Per-thread load/store unit that consumes the `rs`/`rt` operands produced by the thread's register file and returns `lsu_out` for MEMORY-mux write-back. It turns decoded LDR/STR instructions into a valid/ready transaction on the data-memory controller port. It reports progress to the core scheduler through `lsu_state`, and the scheduler holds the core in WAIT until every active thread's LSU reaches DONE. One instance sits beside each thread's ALU and register file.

## Interface
- ADDR_BITS, 8, data-memory address width; address is `rs[ADDR_BITS-1:0]`
- DATA_BITS, 8, data width of `rt`, `mem_read_data`, `mem_write_data`, `lsu_out`
- TIMEOUT_CYCLES, 64, handshake watchdog limit; used only with LSU_TIMEOUT_EN
- clk  in  1  sole clock, rising edge
- reset  in  1  one clock; reset is asynchronous and active-low
- enable  in  1  block-level enable; when 0, all state and outputs hold
- thread_active  in  1  thread participates; when 0, no transaction starts
- core_state  in  3  scheduler state: REQUEST=3'b011, WAIT=3'b100, UPDATE=3'b110
- decoded_mem_read_enable  in  1  current instruction is LDR
- decoded_mem_write_enable  in  1  current instruction is STR
- rs  in  DATA_BITS  address operand from the register file
- rt  in  DATA_BITS  store data operand from the register file
- mem_read_valid  out  1  read request
- mem_read_address  out  ADDR_BITS  read address
- mem_read_ready  in  1  read accepted; `mem_read_data` valid this cycle
- mem_read_data  in  DATA_BITS  returned read data
- mem_write_valid  out  1  write request
- mem_write_address  out  ADDR_BITS  write address
- mem_write_data  out  DATA_BITS  write data
- mem_write_ready  in  1  write accepted
- lsu_state  out  2  IDLE=00, REQUESTING=01, WAITING=10, DONE=11
- lsu_out  out  DATA_BITS  last loaded value
- lsu_error  out  1  timeout flag; constant 0 without LSU_TIMEOUT_EN

## Operation
- Reset (`reset`=0) clears, asynchronously, all outputs to 0: `lsu_state`=IDLE, both valids, both addresses, `mem_write_data`, `lsu_out`, `lsu_error`. This includes a reset mid-transaction; the dropped request is not replayed.
- Nothing advances when `enable`=0 or `thread_active`=0. With `thread_active`=0 the LSU stays in IDLE.
- IDLE -> REQUESTING when core_state=REQUEST and a read or write enable is set. If both enables are set, the read wins and the write is ignored for that instruction.
- REQUESTING (the operands are valid this cycle):
  - Read: drive `mem_read_valid`=1 and `mem_read_address`=rs.
  - Write: drive `mem_write_valid`=1, `mem_write_address`=rs, and `mem_write_data`=rt.
  - Next state is WAITING.
- WAITING:
  - Valid and address/data stay stable until the matching ready is sampled high.
  - On ready: deassert valid. For a read, also capture `lsu_out`<=mem_read_data. Next state is DONE.
- DONE -> IDLE only when core_state=UPDATE. Any other core_state holds DONE.
- `lsu_out` holds its value until the next load completes. A store never changes it.
- If core_state changes while the LSU is in REQUESTING or WAITING, the transaction still completes.

## Timing
- Registered outputs only. There are no combinational paths from any input to any output.
- Minimum load latency, with ready already high:
  - Edge 1 (REQUEST sampled): lsu_state=REQUESTING.
  - Edge 2: valid=1, WAITING.
  - Edge 3: DONE, with `lsu_out` updated.
- Each extra cycle that ready stays low adds one cycle in WAITING.
- Ready is ignored outside WAITING.
- Exactly one valid cycle pulse is acknowledged per transaction. The valid falls on the edge that samples ready high.

## Configuration
- LSU_TIMEOUT_EN defined:
  - A counter runs in WAITING and is cleared on leaving WAITING.
  - On reaching TIMEOUT_CYCLES without ready, the LSU deasserts valid and sets `lsu_error`=1. A read also sets `lsu_out`=0. The state goes to DONE.
  - `lsu_error` clears when the next transaction enters REQUESTING.
- LSU_TIMEOUT_EN undefined: WAITING waits indefinitely, `lsu_error` is tied to 0, and no counter is built.

## Structure
- Shared package `gpu_pkg`:
  - core_state constants (REQUEST, WAIT, UPDATE, DONE=3'b111).
  - The lsu_state typedef/encoding.
  - The register input-mux constants (ARITHMETIC, MEMORY, CONSTANT), shared with the register file and the scheduler.
- Optional sub-module `lsu_watchdog`: loadable counter with clear, enable, and `expired` output. It is instantiated only under LSU_TIMEOUT_EN.

## Test plan
- Load, ready immediately high, mem_read_data=8'hA5, rs=8'h12:
  - mem_read_address=8'h12 at edge 2.
  - lsu_out=8'hA5 and DONE at edge 3.
  - IDLE one edge after core_state=UPDATE.
- Store with rs=8'h40, rt=8'h3C, ready delayed 5 cycles:
  - mem_write_valid is held high for 6 cycles with address and data stable.
  - lsu_out is unchanged.
- thread_active=0 with LDR in REQUEST: lsu_state stays IDLE and no valid is ever asserted.
- Both enables set: only mem_read_valid pulses, and mem_write_valid stays 0.
- reset asserted while in WAITING: every output reads 0 immediately, without waiting for a clock edge.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4 and ready never high: lsu_error=1, lsu_out=0, and DONE is reached after 4 WAITING cycles.
